stopwatch_ctrl: RTL and testbench

Front-panel controller for the stopwatch counter. It debounces three synchronized push-button levels and turns them into one-cycle press events. A Moore FSM uses those events to drive the counter's enable, clear and display-hold controls. It sits between the button synchronizers and the counter, so the counter only ever sees clean, legal control sequences.

---
 rtl/stopwatch_ctrl.sv | 155 +++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front panel: per-button debounce with press-edge detect, feeding
// a Moore FSM that sequences the counter's enable, clear and display hold.

module sw_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic press_o
);
    localparam int CW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          lvl_dly_q;

    // Any edge agreeing with the accepted level restarts the qualification run.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (raw_i != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) lvl_d = raw_i;
            else                            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            lvl_q     <= 1'b0;
            lvl_dly_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            lvl_q     <= lvl_d;
            lvl_dly_q <= lvl_q;
        end
    end

    assign press_o = lvl_q & ~lvl_dly_q;
endmodule

module stopwatch_ctrl #(
    parameter int DEBOUNCE  = 4,
    parameter int CLEAR_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop_btn,
    input  logic       lap_btn,
    input  logic       reset_btn,
    output logic       cnt_ena,
    output logic       cnt_clear,
    output logic       cnt_hold,
    output logic [2:0] state,
    output logic       running
);
    localparam int NUM_BTN = 3;
    localparam int BTN_RST = 0;
    localparam int BTN_SS  = 1;
    localparam int BTN_LAP = 2;
    localparam int CCW     = (CLEAR_LEN < 2) ? 1 : $clog2(CLEAR_LEN);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_PAUSE     = 3'd2,
        S_LAP       = 3'd3,
        S_LAP_PAUSE = 3'd4,
        S_CLEAR     = 3'd5
    } state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_press;

    assign btn_raw = {lap_btn, start_stop_btn, reset_btn};

    for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
        sw_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
            .clk    (clk),
            .rst    (rst),
            .raw_i  (btn_raw[b]),
            .press_o(btn_press[b])
        );
    end

    state_t         state_q, state_d;
    logic [CCW-1:0] clr_cnt_q, clr_cnt_d;

    logic ev_rst, ev_ss, ev_lap;
    assign ev_rst = btn_press[BTN_RST];
    assign ev_ss  = btn_press[BTN_SS];
    assign ev_lap = btn_press[BTN_LAP];

    // Branch order inside each state encodes reset > start_stop > lap, and
    // only events legal in that state are tested, so lower ones can still win.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = '0;
        unique case (state_q)
            S_IDLE: begin
                if      (ev_rst) state_d = S_CLEAR;
                else if (ev_ss)  state_d = S_RUN;
            end
            S_RUN: begin
                if      (ev_ss)  state_d = S_PAUSE;
                else if (ev_lap) state_d = S_LAP;
            end
            S_PAUSE: begin
                if      (ev_rst) state_d = S_CLEAR;
                else if (ev_ss)  state_d = S_RUN;
            end
            S_LAP: begin
                if      (ev_ss)  state_d = S_LAP_PAUSE;
                else if (ev_lap) state_d = S_RUN;
            end
            S_LAP_PAUSE: begin
                if      (ev_rst) state_d = S_CLEAR;
                else if (ev_ss)  state_d = S_LAP;
                else if (ev_lap) state_d = S_PAUSE;
            end
            S_CLEAR: begin
                if (clr_cnt_q == CCW'(CLEAR_LEN - 1)) state_d = S_IDLE;
                else                                 clr_cnt_d = clr_cnt_q + CCW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        cnt_ena   = 1'b0;
        cnt_clear = 1'b0;
        cnt_hold  = 1'b0;
        unique case (state_q)
            S_RUN:       cnt_ena = 1'b1;
            S_LAP:       begin cnt_ena = 1'b1; cnt_hold = 1'b1; end
            S_LAP_PAUSE: cnt_hold = 1'b1;
            S_CLEAR:     cnt_clear = 1'b1;
            default:     ;
        endcase
    end

    assign state   = state_q;
    assign running = cnt_ena;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: constant-vector table, directed multi-cycle
// sequences, and random button traffic against a history-based reference.

module tb_stopwatch_ctrl;
    localparam int DEBOUNCE  = 4;
    localparam int CLEAR_LEN = 2;
    localparam bit [2:0] B_NONE = 3'b000;
    localparam bit [2:0] B_RST  = 3'b001;
    localparam bit [2:0] B_SS   = 3'b010;
    localparam bit [2:0] B_LAP  = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start_stop_btn = 1'b0;
    logic       lap_btn = 1'b0;
    logic       reset_btn = 1'b0;
    logic       cnt_ena, cnt_clear, cnt_hold, running;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    stopwatch_ctrl #(.DEBOUNCE(DEBOUNCE), .CLEAR_LEN(CLEAR_LEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_stop_btn(start_stop_btn),
        .lap_btn       (lap_btn),
        .reset_btn     (reset_btn),
        .cnt_ena       (cnt_ena),
        .cnt_clear     (cnt_clear),
        .cnt_hold      (cnt_hold),
        .state         (state),
        .running       (running)
    );

    always #5 clk = ~clk;

    // Reference model: transition table indexed [state][event], event order
    // is priority order (0=reset, 1=start_stop, 2=lap); -1 means ignored.
    int nxt[6][3];
    int o_ena[6];
    int o_clr[6];
    int o_hold[6];

    int        m_state;
    int        m_clr_cycles;
    bit        m_acc[3];
    bit        m_accd[3];
    bit [31:0] m_hist[3];
    int        m_nsamp;

    function automatic void model_edge(bit r, bit [2:0] raw);
        bit ev[3];
        bit [31:0] mask;
        int ns;
        if (r) begin
            m_state = 0; m_clr_cycles = 0; m_nsamp = 0;
            for (int b = 0; b < 3; b++) begin
                m_acc[b] = 0; m_accd[b] = 0; m_hist[b] = '0;
            end
            return;
        end
        for (int b = 0; b < 3; b++) ev[b] = m_acc[b] & ~m_accd[b];
        if (m_state == 5) begin
            if (m_clr_cycles == CLEAR_LEN) m_state = 0;
            else m_clr_cycles++;
        end else begin
            for (int b = 0; b < 3; b++) begin
                ns = nxt[m_state][b];
                if (ev[b] && ns >= 0) begin
                    m_state = ns;
                    if (ns == 5) m_clr_cycles = 1;
                    break;
                end
            end
        end
        // A level is accepted once the last DEBOUNCE samples all disagree with it.
        mask = (32'd1 << DEBOUNCE) - 32'd1;
        m_nsamp++;
        for (int b = 0; b < 3; b++) begin
            m_accd[b] = m_acc[b];
            m_hist[b] = {m_hist[b][30:0], raw[b]};
            if (m_nsamp >= DEBOUNCE && (m_hist[b] & mask) == (m_acc[b] ? 32'd0 : mask))
                m_acc[b] = raw[b];
        end
    endfunction

    function automatic int model_out();
        return (m_state << 4) | (o_ena[m_state] << 3) | (o_clr[m_state] << 2)
             | (o_hold[m_state] << 1) | o_ena[m_state];
    endfunction

    function automatic int dut_out();
        return (int'(state) << 4) | (int'(cnt_ena) << 3) | (int'(cnt_clear) << 2)
             | (int'(cnt_hold) << 1) | int'(running);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit [2:0] b);
        rst = r; reset_btn = b[0]; start_stop_btn = b[1]; lap_btn = b[2];
        @(posedge clk);
        model_edge(r, b);
        #1;
        check("model", dut_out(), model_out());
        check("ena_clr_excl", int'(cnt_ena & cnt_clear), 0);
    endtask

    // Hold buttons DEBOUNCE+1 edges (event acted on at the last), then release.
    task automatic press(input bit [2:0] m, output int st_evt);
        for (int i = 0; i <= DEBOUNCE; i++) step(1'b0, m);
        st_evt = int'(state);
        for (int i = 0; i <= DEBOUNCE; i++) step(1'b0, B_NONE);
    endtask

    typedef struct {
        bit       r;
        bit [2:0] b;
        int       st;
        int       ena;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(bit r, bit [2:0] b, int st, int ena, int n);
        vec_t v;
        v.r = r; v.b = b; v.st = st; v.ena = ena;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    initial begin
        int st, clrs;
        int left[3];
        bit [2:0] lvl;

        nxt    = '{'{5, 1, -1}, '{-1, 2, 3}, '{5, 1, -1}, '{-1, 4, 1}, '{5, 3, 2}, '{-1, -1, -1}};
        o_ena  = '{0, 1, 0, 1, 0, 0};
        o_clr  = '{0, 0, 0, 0, 0, 1};
        o_hold = '{0, 0, 0, 1, 1, 0};

        // Glitch filter, then start after reset with latency DEBOUNCE+1.
        add(1, B_NONE, 0, 0, 1);
        add(0, B_SS,   0, 0, 3);
        add(0, B_NONE, 0, 0, 3);
        add(0, B_SS,   0, 0, 4);
        add(0, B_NONE, 1, 1, 5);
        add(1, B_NONE, 0, 0, 1);
        add(0, B_SS,   0, 0, 4);
        add(0, B_SS,   1, 1, 2);
        add(0, B_NONE, 1, 1, 5);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].b);
            check($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
            check($sformatf("vec%0d_ena", i), int'(cnt_ena), vecs[i].ena);
        end

        // Lap cycle from RUN.
        press(B_LAP, st);
        check("lap_state", st, 3);
        check("lap_hold", int'(cnt_hold), 1);
        check("lap_ena", int'(cnt_ena), 1);
        press(B_SS, st);
        check("lappause_state", st, 4);
        check("lappause_ena", int'(cnt_ena), 0);
        press(B_LAP, st);
        check("lap_to_pause", st, 2);
        check("pause_hold", int'(cnt_hold), 0);
        press(B_SS, st);
        check("pause_to_run", st, 1);

        // Priority and illegal events.
        press(B_RST, st);
        check("run_ignores_reset", st, 1);
        press(B_LAP | B_SS, st);
        check("run_ss_beats_lap", st, 2);
        press(B_RST | B_SS, st);
        check("pause_reset_beats_ss", st, 5);
        check("after_clear_idle", int'(state), 0);

        // Clear from PAUSE with a start_stop press landing inside CLEAR.
        press(B_SS, st);
        press(B_SS, st);
        check("back_to_pause", st, 2);
        clrs = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, {1'b0, (i >= 1 && i < 6), (i < 5)});
            clrs += int'(cnt_clear);
        end
        check("clear_len", clrs, CLEAR_LEN);
        check("clear_drops_ss", int'(state), 0);

        // Reset from LAP with start_stop held through reset.
        press(B_SS, st);
        press(B_LAP, st);
        check("in_lap_hold", int'(cnt_hold), 1);
        step(1'b0, B_SS);
        step(1'b0, B_SS);
        step(1'b1, B_SS);
        check("rst_state", int'(state), 0);
        check("rst_hold", int'(cnt_hold), 0);
        check("rst_ena", int'(cnt_ena), 0);
        for (int k = 1; k <= DEBOUNCE + 1; k++) begin
            step(1'b0, B_SS);
            if (k == DEBOUNCE)     check("held_not_yet", int'(state), 0);
            if (k == DEBOUNCE + 1) check("held_run", int'(state), 1);
        end
        for (int i = 0; i <= DEBOUNCE; i++) step(1'b0, B_NONE);

        // Random button traffic with occasional resets.
        lvl = '0;
        for (int b = 0; b < 3; b++) left[b] = $urandom_range(1, 10);
        for (int n = 0; n < 4000; n++) begin
            for (int b = 0; b < 3; b++) begin
                if (--left[b] == 0) begin
                    lvl[b] = ~lvl[b];
                    left[b] = $urandom_range(1, 12);
                end
            end
            step($urandom_range(0, 199) == 0, lvl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
